// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;
  localparam int NUM_DIGITS = 8;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef logic [7:0] seg_pat_t;
  typedef seg_pat_t [NUM_DIGITS-1:0] seg_frame_t;

  typedef enum logic {
    BLANK,
    SHOW
  } scan_state_t;
endpackage

// File: rtl/seg_slot_timer.sv
// Per-slot timer: DEAD blank cycles then SHOW until the slot ends.
// Exposes the low counter bits when SEG_SCAN_DIM_EN is defined.
module seg_slot_timer
  import seg_pkg::*;
#(
  parameter int DIV  = 10,
  parameter int DEAD = 2,
  parameter int CW   = 4
) (
  input  logic       clk,
  input  logic       rst,
`ifdef SEG_SCAN_DIM_EN
  output logic [3:0] cnt_lo,
`endif
  output logic       show_en,
  output logic       slot_end
);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD - 1);
  // With no dead time the slot never leaves SHOW.
  localparam scan_state_t START_ST =
    (DEAD == 0) ? SHOW : BLANK;

  scan_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= START_ST;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    show_en   = 1'b0;
    slot_end  = 1'b0;
    unique case (state)
      BLANK: begin
        if (cnt == DEAD_LAST) state_nxt = SHOW;
      end
      SHOW: begin
        show_en = 1'b1;
        if (cnt == LAST) begin
          slot_end  = 1'b1;
          cnt_nxt   = '0;
          state_nxt = START_ST;
        end
      end
    endcase
  end

`ifdef SEG_SCAN_DIM_EN
  assign cnt_lo = cnt[3:0];
`endif
endmodule

// File: rtl/seg_scan_ctrl.sv
// Tear-free 8-digit seven-segment scan controller with dead time.
// Define SEG_SCAN_DIM_EN to add the 4-bit bright PWM input.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int SCAN_HZ     = 1000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] seg_pattern,
  input  logic [7:0]  digit_mask,
  input  logic        upd_valid,
`ifdef SEG_SCAN_DIM_EN
  input  logic [3:0]  bright,
`endif
  output logic        upd_ready,
  output logic [7:0]  seg_out,
  output logic [7:0]  an_out,
  output logic        frame_done
);
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW  = (DIV > 16) ? $clog2(DIV) : 4;

  if (DEAD_CYCLES >= DIV) begin : g_bad_dead
    $error("DEAD_CYCLES must be below CLK_HZ/SCAN_HZ");
  end

  logic       show_en, slot_end, boundary;
  logic       pending, xfer, dim_on;
  logic [2:0] digit_idx;
  logic [7:0] mask_sh, pend_mask;
  logic [7:0] seg_nxt, an_nxt;
  seg_frame_t shadow, pend_frame;

`ifdef SEG_SCAN_DIM_EN
  logic [3:0] cnt_lo, bright_sh;
`endif

  seg_slot_timer #(
    .DIV  (DIV),
    .DEAD (DEAD_CYCLES),
    .CW   (CW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
`ifdef SEG_SCAN_DIM_EN
    .cnt_lo   (cnt_lo),
`endif
    .show_en  (show_en),
    .slot_end (slot_end)
  );

  assign boundary   = slot_end && (digit_idx == 3'd7);
  assign frame_done = boundary;
  assign upd_ready  = ~pending;
  assign xfer       = upd_valid && ~pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_idx  <= '0;
      pending    <= 1'b0;
      pend_frame <= {NUM_DIGITS{SEG_BLANK}};
      pend_mask  <= '0;
      shadow     <= {NUM_DIGITS{SEG_BLANK}};
      mask_sh    <= '0;
    end else begin
      if (slot_end) digit_idx <= digit_idx + 3'd1;
      // xfer needs pending=0, so it never shares a cycle with an apply.
      if (boundary && pending) begin
        shadow  <= pend_frame;
        mask_sh <= pend_mask;
        pending <= 1'b0;
      end else if (xfer) begin
        pend_frame <= seg_frame_t'(seg_pattern);
        pend_mask  <= digit_mask;
        pending    <= 1'b1;
      end
    end
  end

`ifdef SEG_SCAN_DIM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bright_sh <= 4'hF;
    else if (boundary) bright_sh <= bright;
  end

  assign dim_on = cnt_lo < bright_sh;
`else
  assign dim_on = 1'b1;
`endif

  always_comb begin
    seg_nxt = SEG_BLANK;
    an_nxt  = SEG_BLANK;
    if (show_en && mask_sh[digit_idx]) begin
      seg_nxt = shadow[digit_idx];
      if (dim_on) an_nxt = ~(8'b1 << digit_idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_out <= SEG_BLANK;
      an_out  <= SEG_BLANK;
    end else begin
      seg_out <= seg_nxt;
      an_out  <= an_nxt;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: DIV=10, DEAD=2, reference model
// driven by absolute cycle position since reset release.
module tb_seg_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] seg_pattern;
  logic [7:0]  digit_mask;
  logic        upd_valid;
  logic        upd_ready;
  logic [7:0]  seg_out;
  logic [7:0]  an_out;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  // reference model state
  int          pos;
  logic [63:0] m_shadow;
  logic [7:0]  m_mask;
  logic [63:0] m_pbuf;
  logic [7:0]  m_pmask;
  bit          m_pend;

  seg_scan_ctrl #(
    .CLK_HZ      (1000),
    .SCAN_HZ     (100),
    .DEAD_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_pattern (seg_pattern),
    .digit_mask  (digit_mask),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .seg_out     (seg_out),
    .an_out      (an_out),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Display for a slot position: 10-cycle slots, 2 blank, 8 digits.
  function automatic logic [15:0] disp(input int p);
    int d, c;
    d = (p / 10) % 8;
    c = p % 10;
    if (c < 2 || !m_mask[d]) return 16'hFFFF;
    return {~(8'd1 << d), m_shadow[8*d +: 8]};
  endfunction

  task automatic model_reset();
    pos      = 0;
    m_shadow = '1;
    m_mask   = '0;
    m_pbuf   = '1;
    m_pmask  = '0;
    m_pend   = 0;
  endtask

  task automatic check_all(input logic [15:0] exp);
    check("an_out", an_out, exp[15:8]);
    check("seg_out", seg_out, exp[7:0]);
    check("upd_ready", {7'd0, upd_ready}, {7'd0, !m_pend});
    check("frame_done", {7'd0, frame_done},
          {7'd0, (pos % 80) == 79});
  endtask

  // One clock: inputs already driven at the current negedge.
  task automatic step();
    logic [15:0] exp;
    bit xfer;
    exp  = disp(pos);
    xfer = upd_valid && !m_pend;
    if ((pos % 80) == 79 && m_pend) begin
      m_shadow = m_pbuf;
      m_mask   = m_pmask;
      m_pend   = 0;
    end
    if (xfer) begin
      m_pbuf  = seg_pattern;
      m_pmask = digit_mask;
      m_pend  = 1;
    end
    @(posedge clk);
    pos++;
    @(negedge clk);
    check_all(exp);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic go_to(input int ph);
    for (int i = 0; i < 80 && (pos % 80) != ph; i++) step();
  endtask

  task automatic offer(input logic [63:0] p, input logic [7:0] m);
    seg_pattern = p;
    digit_mask  = m;
    upd_valid   = 1'b1;
    step();
    upd_valid   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    upd_valid = 1'b0;
    seg_pattern = '0;
    digit_mask = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all(16'hFFFF);

    // idle: blank display, periodic frame_done
    run(170);

    // full frame, all digits
    offer(64'hC0F9A4B0_999282F8, 8'hFF);
    run(170);

    // only digits 0 and 2 enabled
    offer({$urandom, $urandom}, 8'b0000_0101);
    run(170);

    // B offered while A pending is ignored, accepted later
    go_to(30);
    offer(64'h0123456789ABCDEF, 8'hFF);
    seg_pattern = 64'hFEDCBA9876543210;
    digit_mask  = 8'h5A;
    upd_valid   = 1'b1;
    run(100);
    upd_valid = 1'b0;
    run(170);

    // offer exactly on the boundary cycle
    go_to(79);
    offer(64'h8080808080808080, 8'hF0);
    run(170);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      upd_valid   = ($urandom_range(0, 15) == 0);
      seg_pattern = {$urandom, $urandom};
      digit_mask  = 8'($urandom_range(0, 255));
      step();
    end
    upd_valid = 1'b0;
    run(170);

    // reset mid digit 3 SHOW with a frame pending
    go_to(20);
    offer(64'h1111111111111111, 8'hFF);
    go_to(35);
    rst = 1'b1;
    #1;
    model_reset();
    check("rst an_out", an_out, 8'hFF);
    check("rst seg_out", seg_out, 8'hFF);
    check("rst upd_ready", {7'd0, upd_ready}, 8'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all(16'hFFFF);
    run(170);
    offer(64'h24_30_19_12_02_78_00_10, 8'hFF);
    run(170);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display.
- Accepts a frame of 8 pre-decoded active-low segment patterns (64 bits, as produced by the hex-to-segment translator) plus a per-digit enable mask, through a valid/ready handshake.
- Updates are tear-free: a new frame is applied only at a frame boundary.
- Sits between the CPU's MMIO segment register/decoder and the board pins; inserts dead time between digits to suppress ghosting.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- SCAN_HZ, 1000, per-digit slot rate; DIV = CLK_HZ/SCAN_HZ cycles per slot.
- DEAD_CYCLES, 16, cycles of all-anodes-off at the start of each slot. Elaboration error if DEAD_CYCLES >= DIV.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- seg_pattern  in  64  digit i pattern at [8i+7:8i], active-low segments (bit7 = DP)
- digit_mask  in  8  1 = digit i enabled
- upd_valid  in  1  new frame offered
- upd_ready  out  1  controller can accept a frame
- seg_out  out  8  active-low segment drive
- an_out  out  8  active-low anode enables, one-hot-low or all high
- frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (async, immediate): seg_out=8'hFF, an_out=8'hFF, digit_idx=0, state=BLANK, slot counter=0, shadow patterns=all 8'hFF, shadow mask=0, pending=0, upd_ready=1, frame_done=0.
- Per-slot state machine:
  - BLANK: DEAD_CYCLES cycles; an_out=8'hFF, seg_out=8'hFF.
  - SHOW: DIV-DEAD_CYCLES cycles; seg_out=shadow pattern[digit_idx]; an_out bit digit_idx low if shadow mask bit set, else all high with seg_out=8'hFF.
  - If DEAD_CYCLES=0, BLANK is skipped.
  - SHOW end -> digit_idx+1 (7 wraps to 0) -> BLANK.
- A masked digit still consumes its full slot, so the refresh rate is constant.
- Outputs are registered: an_out/seg_out change one cycle after the state/counter change.
- Handshake:
  - Transfer occurs on upd_valid && upd_ready; seg_pattern and digit_mask are captured into the pending buffer, pending<=1, upd_ready<=0 next cycle.
  - upd_valid may drop without a transfer; no data is kept.
- Frame boundary = last cycle of digit 7's SHOW.
  - If pending: shadow<=pending buffer, pending<=0, upd_ready<=1 on the next cycle.
  - frame_done pulses on the boundary cycle whether or not a frame was pending.
- Simultaneous transfer and boundary: upd_ready was 1, so pending was 0. The captured frame is applied at the next boundary, never the same one.
- While pending=1, further upd_valid is ignored (upd_ready=0). At most one frame is buffered.
- Reset mid-frame: all state is dropped, including the pending frame and shadow; the display blanks until the first post-reset frame is applied.

Optional Feature:
- Macro SEG_SCAN_DIM_EN.
- With it: extra input port bright, 4 bits.
  - Sampled into a shadow register at each frame boundary.
  - During SHOW, the enabled anode is asserted only while slot_counter[3:0] < bright_shadow, with seg_out held.
  - bright=0 blanks the display; bright=15 gives 15/16 duty.
  - Reset value of bright_shadow is 15.
- Without it: no port; full duty during SHOW.

Decomposition:
- Package seg_pkg:
  - NUM_DIGITS=8.
  - SEG_BLANK=8'hFF.
  - typedef seg_pat_t (logic[7:0]).
  - typedef seg_frame_t (seg_pat_t [7:0]).
  - enum scan_state_t {BLANK, SHOW}.
- One natural sub-module, seg_slot_timer: DIV/DEAD counter emitting show_en and slot_end strobes.
- Handshake, shadow registers and output muxing remain in seg_scan_ctrl.

Test Plan (CLK_HZ=1000, SCAN_HZ=100 -> DIV=10, DEAD_CYCLES=2):
- Reset, no update -> an_out=8'hFF and seg_out=8'hFF for all cycles; frame_done pulses every 80 cycles; upd_ready=1.
- Send seg_pattern=64'hC0F9A4B0_999282F8 with digit_mask=8'hFF -> after the next boundary, each digit i shows its byte for 8 cycles with an_out=~(1<<i), preceded by 2 cycles of 8'hFF/8'hFF.
- digit_mask=8'b0000_0101 -> only an_out=8'hFE and 8'hFB are ever driven low; all other slots stay fully blank for 10 cycles.
- Offer frame B while frame A is pending -> upd_ready=0 and B is ignored. A appears at the boundary; upd_ready returns to 1 one cycle later; B accepted afterwards appears one frame later.
- Assert upd_valid exactly on the boundary cycle -> the frame is not displayed in the immediately following frame; it is displayed after the next frame_done.
- Assert rst in the middle of digit 3's SHOW with a frame pending -> outputs go to 8'hFF/8'hFF asynchronously. After release: digit_idx=0, upd_ready=1, and no stale frame is ever displayed.
